// File: rtl/dmem_arbiter_pkg.sv
// Shared types and default geometry for the data-memory arbiter slice.
package dmem_pkg;

    localparam int unsigned DMEM_ADDR_W = 13;
    localparam int unsigned DMEM_DATA_W = 32;

    // Bit positions of the two requesters in request/grant vectors.
    localparam int unsigned REQ_CPU = 0;
    localparam int unsigned REQ_EXT = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_CPU = 2'd1,
        RD_EXT = 2'd2
    } state_e;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_EXT = 1'b1
    } grant_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundles the MEM-stage, external-requester and memory-macro signals of the arbiter.
interface dmem_arbiter_if
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = DMEM_ADDR_W,
    parameter int unsigned DATA_W = DMEM_DATA_W
) ();

    logic [3:0]        cpu_mem_read;
    logic [3:0]        cpu_mem_write;
    logic [31:0]       cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              ext_valid;
    logic              ext_write;
    logic [3:0]        ext_be;
    logic [31:0]       ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_ready;
    logic              ext_rvalid;
    logic [DATA_W-1:0] ext_rdata;

    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  cpu_mem_read, cpu_mem_write, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  ext_valid, ext_write, ext_be, ext_addr, ext_wdata,
        output ext_ready, ext_rvalid, ext_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Environment side: pipeline, external requester and memory macro.
    modport master (
        output cpu_mem_read, cpu_mem_write, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output ext_valid, ext_write, ext_be, ext_addr, ext_wdata,
        input  ext_ready, ext_rvalid, ext_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; sole owner of the last_grant history.
module rr_arbiter2
    import dmem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    grant_e last_grant_q;
    grant_e last_grant_d;

    // On a tie the requester not served last wins; a lone requester wins outright.
    always_comb begin
        gnt_o = '0;
        if (en_i) begin
            if (req_i[REQ_CPU] && (!req_i[REQ_EXT] || last_grant_q == GNT_EXT)) begin
                gnt_o[REQ_CPU] = 1'b1;
            end else if (req_i[REQ_EXT]) begin
                gnt_o[REQ_EXT] = 1'b1;
            end
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (gnt_o[REQ_CPU]) begin
            last_grant_d = GNT_CPU;
        end else if (gnt_o[REQ_EXT]) begin
            last_grant_d = GNT_EXT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= GNT_EXT;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the MEM stage and an external requester,
// with read-return FSM and pipeline stall generation.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = DMEM_ADDR_W,
    parameter int unsigned DATA_W = DMEM_DATA_W
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);

    state_e state_q;
    state_e state_d;

    logic       cpu_req;
    logic       cpu_is_wr;
    logic [3:0] cpu_be;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       gnt_en;

    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic [3:0]        we_sel;

    // Byte offset and address bits above the memory size are ignored by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.cpu_addr[31:ADDR_W+2], bus.cpu_addr[1:0],
                                bus.ext_addr[31:ADDR_W+2], bus.ext_addr[1:0]};

    // A simultaneous read+write field pair is treated as a write.
    assign cpu_is_wr = |bus.cpu_mem_write;
    assign cpu_req   = cpu_is_wr || (|bus.cpu_mem_read);
    assign cpu_be    = cpu_is_wr ? bus.cpu_mem_write : 4'h0;

    assign req[REQ_CPU] = cpu_req;
    assign req[REQ_EXT] = bus.ext_valid;
    assign gnt_en       = (state_q == IDLE) && !reset;

    rr_arbiter2 u_rr (
        .clk   (clk),
        .reset (reset),
        .req_i (req),
        .en_i  (gnt_en),
        .gnt_o (gnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Read-return states always last exactly one cycle.
    always_comb begin
        state_d = IDLE;
        if (state_q == IDLE) begin
            if (gnt[REQ_CPU] && !cpu_is_wr) begin
                state_d = RD_CPU;
            end else if (gnt[REQ_EXT] && !bus.ext_write) begin
                state_d = RD_EXT;
            end
        end
    end

    always_comb begin
        addr_sel  = '0;
        wdata_sel = '0;
        we_sel    = '0;
        if (gnt[REQ_CPU]) begin
            addr_sel  = bus.cpu_addr[ADDR_W+1:2];
            wdata_sel = bus.cpu_wdata;
            we_sel    = cpu_be;
        end else if (gnt[REQ_EXT]) begin
            addr_sel  = bus.ext_addr[ADDR_W+1:2];
            wdata_sel = bus.ext_wdata;
            we_sel    = bus.ext_write ? bus.ext_be : 4'h0;
        end
    end

    // Every output is held at zero during reset, including a dropped in-flight read.
    always_comb begin
        bus.mem_en     = 1'b0;
        bus.mem_we     = '0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.cpu_rdata  = '0;
        bus.cpu_stall  = 1'b0;
        bus.ext_ready  = 1'b0;
        bus.ext_rvalid = 1'b0;
        bus.ext_rdata  = '0;
        if (!reset) begin
            bus.mem_en    = |gnt;
            bus.mem_we    = we_sel;
            bus.mem_addr  = addr_sel;
            bus.mem_wdata = wdata_sel;
            bus.ext_ready = gnt[REQ_EXT];
            if (state_q == RD_CPU) begin
                bus.cpu_rdata = bus.mem_rdata;
            end
            if (state_q == RD_EXT) begin
                bus.ext_rvalid = 1'b1;
                bus.ext_rdata  = bus.mem_rdata;
            end
            bus.cpu_stall = cpu_req && !(gnt[REQ_CPU] && cpu_is_wr) && (state_q != RD_CPU);
        end
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port data-memory arbiter between the pipeline's MEM stage and an external requester such as a program loader, debug port or DMA. It sits between the MEM stage and the data-memory macro. It grants one access per cycle using round-robin priority, and it stalls the pipeline whenever the CPU's access cannot complete in the current cycle. The external requester uses a valid/ready handshake, and its read data returns on a separate valid strobe.

## Interface
Parameters:
- ADDR_W, 13, word-address width of the data memory (8K words).
- DATA_W, 32, data width in bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_mem_read  in  4  byte-enable read request from the MEM stage; a nonzero value is a read request.
- cpu_mem_write  in  4  byte-enable write request from the MEM stage; a nonzero value is a write request.
- cpu_addr  in  32  byte address (the ALU result).
- cpu_wdata  in  DATA_W  store data.
- cpu_rdata  out  DATA_W  load data; valid in the cycle cpu_stall falls for a read.
- cpu_stall  out  1  holds the pipeline while high.
- ext_valid  in  1  external request valid.
- ext_write  in  1  1 = write, 0 = read.
- ext_be  in  4  external byte enables.
- ext_addr  in  32  external byte address.
- ext_wdata  in  DATA_W  external write data.
- ext_ready  out  1  request accepted in this cycle.
- ext_rvalid  out  1  one-cycle strobe; ext_rdata is valid while it is high.
- ext_rdata  out  DATA_W  external read data.
- mem_en  out  1  memory access enable.
- mem_we  out  4  memory byte write enables (0 = read).
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  synchronous read data, one cycle after the access.

## Operation
- Request decode:
  - cpu_req = |cpu_mem_read or |cpu_mem_write.
  - If both fields are nonzero, the access is a write using cpu_mem_write.
- Address decode: word address = addr[ADDR_W+1:2]. Bits [1:0] and the bits above ADDR_W+1 are ignored.
- FSM states:
  - IDLE: may issue a new grant.
  - RD_CPU: CPU read data is returning.
  - RD_EXT: external read data is returning.
- IDLE behaviour:
  - If cpu_req and ext_valid are both high, grant the requester that was not granted last (last_grant register).
  - A single requester wins immediately.
  - The granted request drives mem_en=1, mem_we (byte enables for a write, 0 for a read), mem_addr and mem_wdata combinationally.
  - A write completes at the edge that ends the grant cycle; the FSM stays in IDLE.
  - A read moves the FSM to RD_CPU or RD_EXT, according to the winner.
- RD_CPU: cpu_rdata = mem_rdata, cpu_stall = 0, mem_en = 0, next state IDLE. The CPU request still present in this cycle is the one just served and is not re-issued.
- RD_EXT: ext_rvalid = 1, ext_rdata = mem_rdata, mem_en = 0, next state IDLE.
- last_grant updates on every grant.
- cpu_stall = cpu_req and not (a CPU write granted this cycle, or state == RD_CPU).
- ext_ready = 1 only in a cycle where the external request is granted in IDLE.
- Outside RD_CPU, cpu_rdata = 0. Outside RD_EXT, ext_rdata = 0.

## Timing
- Reset values:
  - state = IDLE.
  - last_grant = EXT, so the CPU wins the first tie.
  - In the reset cycle all outputs are forced to 0 (mem_en, mem_we, ext_ready, ext_rvalid, cpu_stall, both rdata buses).
- Latency:
  - CPU write, uncontested: 0 stall cycles.
  - CPU read, uncontested: 1 stall cycle (grant cycle), with data in the following cycle.
  - External read: ext_rvalid exactly 1 cycle after ext_ready.
- Contention:
  - A requester that loses waits for at most one other transaction: write 1 cycle, read 2 cycles.
  - The loser is guaranteed the next grant.
- Handshake: the external requester holds ext_valid and all request fields stable until ext_ready. Changing them before then is illegal.
- Back-to-back external reads: a new grant is issued in the cycle after RD_EXT, never during RD_EXT.
- Reset mid-read: the pending read is dropped. No ext_rvalid is issued and cpu_stall is 0 in the reset cycle. The CPU request, if still held, is re-arbitrated from IDLE afterwards.
- A request that deasserts before it is granted is simply not served. No state is kept per requester except last_grant.

## Structure
- Package dmem_pkg holds:
  - the state enum (IDLE, RD_CPU, RD_EXT);
  - the grant enum (GNT_CPU, GNT_EXT);
  - the default ADDR_W and DATA_W constants.
- Sub-module rr_arbiter2: two request inputs, a grant-enable input and a one-hot grant output. It owns the last_grant register and is the only place it lives.
- dmem_arbiter holds the FSM, the output muxing and the stall logic.

## Test plan
- CPU write only: cpu_mem_write=4'hF, cpu_addr=0x10, cpu_wdata=0xABCDE.
  - Required: cpu_stall=0, mem_en=1, mem_we=4'hF, mem_addr=4.
  - A later read of 0x10 returns 0xABCDE.
- CPU read only: cpu_mem_read=4'hF, cpu_addr=0x10.
  - Required: cpu_stall=1 for exactly 1 cycle, then cpu_rdata=0xABCDE with cpu_stall=0.
- Tie after reset: the CPU reads 0x0 while the external requester reads 0x8, both in the same cycle.
  - Required: CPU granted first (2 cycles), then ext_ready.
  - ext_rvalid follows 1 cycle after ext_ready with memory[2].
- Round-robin: both sides issue writes continuously.
  - Required: grants alternate CPU, EXT, CPU, EXT.
  - cpu_stall is high only in the EXT-grant cycles.
- Reset mid-read: assert reset in the cycle after an external read grant.
  - Required: no ext_rvalid and all outputs 0 in the reset cycle.
  - The next CPU write is granted with 0 stall cycles.
